eth_burst_arbiter: RTL and testbench

Shares the single Ethernet transmit path between the two ADC/convolution channel FIFOs. It watches each FIFO's read-side fill count and grants whole fixed-length bursts in round-robin order. It drives the FIFO read requests and presents a framed word stream (start, valid, last, channel, sequence number) to the packet builder. It sits on the Ethernet TX clock domain, between the `fifo_acp` read ports and the Ethernet packet engine.

---
 rtl/eth_burst_arbiter.sv | 169 ++++++++++++++++
 tb/tb_eth_burst_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_burst_arbiter.sv
// Round-robin burst arbiter between two channel FIFOs feeding the Ethernet TX packet engine.
// Optional per-channel sequence counters are built when ETH_ARB_SEQ_EN is defined.
module eth_burst_arbiter #(
   parameter int DATA_W     = 16,
   parameter int CNT_W      = 9,
   parameter int BURST_LEN  = 256,
   parameter int GAP_CYCLES = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              tx_ready,
   input  logic [CNT_W-1:0]  ch0_count,
   input  logic [CNT_W-1:0]  ch1_count,
   input  logic [DATA_W-1:0] ch0_data,
   input  logic [DATA_W-1:0] ch1_data,
   output logic              ch0_rdreq,
   output logic              ch1_rdreq,
   output logic              tx_start,
   output logic              tx_chan,
   output logic [15:0]       tx_seq,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   output logic              tx_last,
   output logic              busy
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] BURST_THR = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(BURST_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_READ,
      S_DRAIN,
      S_GAP
   } state_t;

   state_t             state_q, state_d;
   logic               chan_q, chan_d;
   logic               prio_q, prio_d;
   logic [CNT_W-1:0]   word_q, word_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               grant;
   logic               elig0, elig1;

   logic               ch0_rdreq_q, ch1_rdreq_q;
   logic               tx_start_q, tx_valid_q, tx_last_q, busy_q;
   logic [DATA_W-1:0]  tx_data_q;

   assign elig0 = (ch0_count >= BURST_THR);
   assign elig1 = (ch1_count >= BURST_THR);

   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      prio_d  = prio_q;
      word_d  = word_q;
      gap_d   = gap_q;
      grant   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable && tx_ready && (elig0 || elig1)) begin
               grant   = 1'b1;
               chan_d  = (elig0 && elig1) ? prio_q : elig1;
               prio_d  = ~chan_d;
               state_d = S_START;
            end
         end
         S_START: begin
            word_d  = '0;
            state_d = S_READ;
         end
         S_READ: begin
            if (word_q == WORD_LAST) begin
               state_d = S_DRAIN;
            end else begin
               word_d = word_q + 1'b1;
            end
         end
         S_DRAIN: begin
            word_d  = '0;
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output flags are registered from next-state so every output is a flop,
   // and the word read by rdreq is captured at the end of its rdreq cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         chan_q      <= 1'b0;
         prio_q      <= 1'b0;
         word_q      <= '0;
         gap_q       <= '0;
         ch0_rdreq_q <= 1'b0;
         ch1_rdreq_q <= 1'b0;
         tx_start_q  <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_last_q   <= 1'b0;
         tx_data_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         chan_q      <= chan_d;
         prio_q      <= prio_d;
         word_q      <= word_d;
         gap_q       <= gap_d;
         ch0_rdreq_q <= (state_d == S_READ) && !chan_d;
         ch1_rdreq_q <= (state_d == S_READ) && chan_d;
         tx_start_q  <= grant;
         tx_valid_q  <= ch0_rdreq_q | ch1_rdreq_q;
         tx_last_q   <= (state_q == S_READ) && (word_q == WORD_LAST);
         busy_q      <= (state_d != S_IDLE);
         if (ch0_rdreq_q || ch1_rdreq_q) begin
            tx_data_q <= chan_q ? ch1_data : ch0_data;
         end
      end
   end

`ifdef ETH_ARB_SEQ_EN
   logic [15:0] seq0_q, seq1_q, tx_seq_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seq0_q   <= '0;
         seq1_q   <= '0;
         tx_seq_q <= '0;
      end else begin
         if (state_q == S_DRAIN) begin
            if (chan_q) begin
               seq1_q <= seq1_q + 16'd1;
            end else begin
               seq0_q <= seq0_q + 16'd1;
            end
         end
         if (grant) begin
            tx_seq_q <= chan_d ? seq1_q : seq0_q;
         end
      end
   end

   assign tx_seq = tx_seq_q;
`else
   assign tx_seq = '0;
`endif

   assign ch0_rdreq = ch0_rdreq_q;
   assign ch1_rdreq = ch1_rdreq_q;
   assign tx_start  = tx_start_q;
   assign tx_chan   = chan_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign tx_last   = tx_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_eth_burst_arbiter.sv
// Scoreboard bench for eth_burst_arbiter: stimulus pushes expected grants, a negedge monitor
// checks grants, word data/framing and start spacing against a bench-side FIFO model.
module tb_eth_burst_arbiter;

   localparam int DW = 16;
   localparam int CW = 9;
   localparam int BL = 256;
   localparam int GC = 12;

   logic          clk, rst, enable, tx_ready;
   logic [CW-1:0] ch0_count, ch1_count;
   logic [DW-1:0] ch0_data, ch1_data;
   logic          ch0_rdreq, ch1_rdreq, tx_start, tx_chan, tx_valid, tx_last, busy;
   logic [15:0]   tx_seq;
   logic [DW-1:0] tx_data;

   eth_burst_arbiter #(
      .DATA_W(DW), .CNT_W(CW), .BURST_LEN(BL), .GAP_CYCLES(GC)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .tx_ready(tx_ready),
      .ch0_count(ch0_count), .ch1_count(ch1_count),
      .ch0_data(ch0_data), .ch1_data(ch1_data),
      .ch0_rdreq(ch0_rdreq), .ch1_rdreq(ch1_rdreq),
      .tx_start(tx_start), .tx_chan(tx_chan), .tx_seq(tx_seq),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // First-word-fall-through FIFO model: current word is visible, rdreq advances it.
   logic [15:0] idx0 = '0, idx1 = '0;
   always @(posedge clk) begin
      if (ch0_rdreq) idx0 <= idx0 + 16'd1;
      if (ch1_rdreq) idx1 <= idx1 + 16'd1;
   end
   assign ch0_data = 16'hA000 ^ idx0;
   assign ch1_data = 16'h5000 ^ idx1;

   typedef struct packed {
      logic        chan;
      logic [15:0] seq;
   } burst_t;

   burst_t exp_q[$];
   int     start_cyc[$];
   int     total = 0, bad = 0;
   int     cyc = 0, start_cnt = 0, done_cnt = 0, words = 0;
   int     rd_own = 0, rd_other = 0;
   bit     in_burst = 0;
   burst_t cur;
   logic [15:0] eidx0, eidx1;
   int     sq[2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      total++;
      bad++;
      $display("FAIL %s at t=%0t", name, $time);
   endtask

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         exp_q.delete();
         in_burst = 0;
         words    = 0;
         eidx0    = idx0;
         eidx1    = idx1;
      end else begin
         if (tx_start) begin
            start_cnt++;
            start_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               flag("unexpected_start");
               in_burst = 0;
            end else begin
               cur = exp_q.pop_front();
               chk("start_chan", 64'(tx_chan), 64'(cur.chan));
               chk("start_seq", 64'(tx_seq), 64'(cur.seq));
               in_burst = 1;
               words    = 0;
               rd_own   = 0;
               rd_other = 0;
            end
         end
         if (in_burst) begin
            if (cur.chan ? ch1_rdreq : ch0_rdreq) rd_own++;
            if (cur.chan ? ch0_rdreq : ch1_rdreq) rd_other++;
         end else if (ch0_rdreq || ch1_rdreq) begin
            flag("rdreq_outside_burst");
         end
         if (tx_valid) begin
            if (!in_burst) begin
               flag("valid_outside_burst");
            end else begin
               chk("data", 64'(tx_data), 64'(cur.chan ? (16'h5000 ^ eidx1) : (16'hA000 ^ eidx0)));
               if (cur.chan) eidx1 = eidx1 + 16'd1;
               else          eidx0 = eidx0 + 16'd1;
               chk("last_flag", 64'(tx_last), 64'(words == BL - 1));
               chk("chan_hold", 64'(tx_chan), 64'(cur.chan));
               chk("seq_hold", 64'(tx_seq), 64'(cur.seq));
               words++;
               if (tx_last) begin
                  chk("burst_words", 64'(words), 64'(BL));
                  chk("rdreq_count", 64'(rd_own), 64'(BL));
                  chk("other_rdreq", 64'(rd_other), 64'd0);
                  in_burst = 0;
                  done_cnt++;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic expect_burst(input logic ch);
      burst_t b;
      b.chan = ch;
`ifdef ETH_ARB_SEQ_EN
      b.seq = 16'(sq[ch]);
`else
      b.seq = 16'h0000;
`endif
      sq[ch] = sq[ch] + 1;
      exp_q.push_back(b);
   endtask

   task automatic wait_starts(input int n, input int budget, input string name);
      int k = 0;
      while (start_cnt < n && k < budget) begin
         tick(1);
         k++;
      end
      if (start_cnt < n) flag(name);
   endtask

   task automatic wait_done(input int n, input int budget, input string name);
      int k = 0;
      while (done_cnt < n && k < budget) begin
         tick(1);
         k++;
      end
      if (done_cnt < n) flag(name);
   endtask

   task automatic wait_words(input int n, input int budget, input string name);
      int k = 0;
      while (!(in_burst && words >= n) && k < budget) begin
         tick(1);
         k++;
      end
      if (!(in_burst && words >= n)) flag(name);
   endtask

   initial begin
      int s, d;
      rst = 1'b1; enable = 1'b0; tx_ready = 1'b0;
      ch0_count = '0; ch1_count = '0;
      sq[0] = 0; sq[1] = 0;
      tick(3);
      chk("reset_outputs",
          64'({ch0_rdreq, ch1_rdreq, tx_start, tx_chan, tx_seq, tx_data, tx_valid, tx_last, busy}),
          64'd0);
      rst = 1'b0;
      tick(2);

      // Single eligible channel 0.
      enable = 1'b1; tx_ready = 1'b1;
      s = start_cnt; d = done_cnt;
      expect_burst(1'b0);
      ch0_count = 9'd256;
      wait_starts(s + 1, 50, "t1_start_timeout");
      ch0_count = '0;
      wait_done(d + 1, 400, "t1_done_timeout");
      tick(300);
      chk("t1_start_count", 64'(start_cnt), 64'(s + 1));

      // Fresh reset, then both channels eligible: strict alternation.
      rst = 1'b1; tick(2); rst = 1'b0; tick(1);
      sq[0] = 0; sq[1] = 0;
      s = start_cnt; d = done_cnt;
      for (int i = 0; i < 6; i++) expect_burst(1'(i % 2));
      ch0_count = 9'd300; ch1_count = 9'd300;
      wait_starts(s + 6, 6 * 280, "t2_start_timeout");
      ch0_count = '0; ch1_count = '0;
      wait_done(d + 6, 400, "t2_done_timeout");
      if (start_cyc.size() >= s + 6) begin
         for (int i = 1; i < 6; i++)
            chk("t2_spacing", 64'(start_cyc[s+i] - start_cyc[s+i-1]), 64'(BL + GC + 3));
      end else begin
         flag("t2_spacing_missing");
      end

      // Only channel 1 eligible (ch0 one short), then channel 0 becomes eligible.
      s = start_cnt; d = done_cnt;
      expect_burst(1'b1);
      ch0_count = 9'd255; ch1_count = 9'd256;
      wait_starts(s + 1, 300, "t3_ch1_timeout");
      ch1_count = '0;
      expect_burst(1'b0);
      ch0_count = 9'd256;
      wait_starts(s + 2, 600, "t3_ch0_timeout");
      ch0_count = '0;
      wait_done(d + 2, 400, "t3_done_timeout");

      // enable/tx_ready dropped mid-burst: burst completes, no new grant while either is low.
      s = start_cnt; d = done_cnt;
      expect_burst(1'b0);
      ch0_count = 9'd256;
      wait_starts(s + 1, 300, "t4_start_timeout");
      wait_words(100, 300, "t4_word_timeout");
      enable = 1'b0; tx_ready = 1'b0;
      wait_done(d + 1, 400, "t4_done_timeout");
      tick(300);
      chk("t4_no_start_both_low", 64'(start_cnt), 64'(s + 1));
      enable = 1'b1;
      tick(50);
      chk("t4_no_start_ready_low", 64'(start_cnt), 64'(s + 1));
      enable = 1'b0; tx_ready = 1'b1;
      tick(50);
      chk("t4_no_start_enable_low", 64'(start_cnt), 64'(s + 1));
      expect_burst(1'b0);
      enable = 1'b1;
      wait_starts(s + 2, 50, "t4_resume_timeout");
      ch0_count = '0;
      wait_done(d + 2, 400, "t4_resume_done_timeout");

      // Reset mid-burst aborts asynchronously; prio and sequence restart.
      tick(20);
      s = start_cnt;
      expect_burst(1'b0);
      ch0_count = 9'd256;
      wait_starts(s + 1, 300, "t5_start_timeout");
      wait_words(50, 300, "t5_word_timeout");
      chk("t5_pre_reset_rdreq", 64'(ch0_rdreq), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("t5_async_abort", 64'({ch0_rdreq, ch1_rdreq, tx_valid, tx_last, busy, tx_seq}), 64'd0);
      ch0_count = 9'd256; ch1_count = 9'd256;
      tick(3);
      rst = 1'b0;
      sq[0] = 0; sq[1] = 0;
      s = start_cnt; d = done_cnt;
      expect_burst(1'b0);
      expect_burst(1'b1);
      wait_starts(s + 2, 600, "t5_restart_timeout");
      ch0_count = '0; ch1_count = '0;
      wait_done(d + 2, 400, "t5_done_timeout");

      tick(10);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
